ldpc_encode_stream: RTL

Parametrised, multi-cycle systematic LDPC encoder with valid/ready handshakes and an on-chip generator-parity store. It takes K info bits, folds P rows of the parity sub-matrix per cycle, and emits the N-bit codeword {info, check}. It sits between the source framer and the channel-mapping stage, and it replaces the single-cycle, matrix-on-port encoder for large N/K.

---
 rtl/ldpc_encode_stream_pkg.sv | 22 ++
 rtl/ldpc_encode_stream_if.sv | 29 ++
 rtl/ldpc_encode_stream_fold.sv | 18 +
 rtl/ldpc_encode_stream.sv | 120 ++++++++++++
 4 files changed

// File: rtl/ldpc_encode_stream_pkg.sv
// Shared defaults, state encoding and width helper for the folded LDPC encoder.
package ldpc_encode_stream_pkg;

   localparam int N_DEF = 6;
   localparam int K_DEF = 3;
   localparam int P_DEF = 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_DONE  = 2'd2
   } state_e;

   // Never returns less than 1 so that single-entry counters and addresses stay legal.
   function automatic int clog2_f(input int v);
      int r;
      r = 1;
      while ((1 << r) < v) r = r + 1;
      return r;
   endfunction

endpackage

// File: rtl/ldpc_encode_stream_if.sv
// Parity-row write port plus info/codeword handshakes of the folded LDPC encoder.
interface ldpc_encode_stream_if
   import ldpc_encode_stream_pkg::*;
#(
   parameter int N = N_DEF,
   parameter int K = K_DEF
) ();
   localparam int AW = clog2_f(K);

   logic              g_wr_en;
   logic [AW-1:0]     g_wr_addr;
   logic [N-K-1:0]    g_wr_row;
   logic              in_valid;
   logic              in_ready;
   logic [K-1:0]      info_bits;
   logic              out_valid;
   logic              out_ready;
   logic [N-1:0]      codeword;

   modport master (
      output g_wr_en, g_wr_addr, g_wr_row, in_valid, info_bits, out_ready,
      input  in_ready, out_valid, codeword
   );

   modport slave (
      input  g_wr_en, g_wr_addr, g_wr_row, in_valid, info_bits, out_ready,
      output in_ready, out_valid, codeword
   );
endinterface

// File: rtl/ldpc_encode_stream_fold.sv
// Combinational GF(2) fold of P parity rows, each gated by its info bit, into the accumulator.
module ldpc_parity_fold #(
   parameter int N = 6,
   parameter int K = 3,
   parameter int P = 1
) (
   input  logic [P-1:0]              info_chunk_i,
   input  logic [P-1:0][N-K-1:0]     rows_i,
   input  logic [N-K-1:0]            acc_i,
   output logic [N-K-1:0]            acc_o
);
   always_comb begin
      acc_o = acc_i;
      for (int p = 0; p < P; p++) begin
         if (info_chunk_i[p]) acc_o = acc_o ^ rows_i[p];
      end
   end
endmodule

// File: rtl/ldpc_encode_stream.sv
// Systematic LDPC encoder folding P parity rows per cycle; emits {info, check}.
//  state    | meaning
//  ST_IDLE  | store writable, waiting for an info word
//  ST_ACCUM | folding chunk c of the parity sub-matrix into the accumulator
//  ST_DONE  | codeword registered, waiting for the sink
module ldpc_encode_stream
   import ldpc_encode_stream_pkg::*;
#(
   parameter int N = N_DEF,
   parameter int K = K_DEF,
   parameter int P = P_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   ldpc_encode_stream_if.slave   bus,
   output logic                  busy_o
);
   localparam int CW  = N - K;
   localparam int NCH = K / P;
   localparam int CCW = clog2_f(NCH);

   if ((K % P) != 0 || K >= N || P < 1) begin : g_param_check
      $error("ldpc_encode_stream: need K < N and K divisible by P");
   end

   state_e                 state_q, state_d;
   logic [CCW-1:0]         c_q, c_d;
   logic [CW-1:0]          acc_q, acc_d, acc_next;
   logic [K-1:0]           info_q, info_d;
   logic [N-1:0]           cw_q, cw_d;
   logic                   ov_q, ov_d;
   logic [K-1:0][CW-1:0]   g_q, g_d;
   logic [P-1:0]           chunk_info;
   logic [P-1:0][CW-1:0]   chunk_rows;
   logic                   in_ready;

   assign in_ready      = (state_q == ST_IDLE) && !bus.g_wr_en;
   assign bus.in_ready  = in_ready;
   assign bus.out_valid = ov_q;
   assign bus.codeword  = cw_q;
   assign busy_o        = (state_q != ST_IDLE);

   always_comb begin
      chunk_info = info_q[int'(c_q) * P +: P];
      chunk_rows = g_q[int'(c_q) * P +: P];
   end

   ldpc_parity_fold #(.N(N), .K(K), .P(P)) u_fold (
      .info_chunk_i (chunk_info),
      .rows_i       (chunk_rows),
      .acc_i        (acc_q),
      .acc_o        (acc_next)
   );

   // The store is only writable in IDLE, so rows are frozen for the word in flight.
   always_comb begin
      g_d = g_q;
      if (state_q == ST_IDLE && bus.g_wr_en) begin
         for (int j = 0; j < K; j++) begin
            if (int'(bus.g_wr_addr) == j) g_d[j] = bus.g_wr_row;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      c_d     = c_q;
      acc_d   = acc_q;
      info_d  = info_q;
      cw_d    = cw_q;
      ov_d    = ov_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.in_valid && in_ready) begin
               state_d = ST_ACCUM;
               info_d  = bus.info_bits;
               acc_d   = '0;
               c_d     = '0;
            end
         end
         ST_ACCUM: begin
            acc_d = acc_next;
            c_d   = c_q + CCW'(1);
            if (c_q == CCW'(NCH - 1)) begin
               state_d = ST_DONE;
               c_d     = '0;
               cw_d    = {info_q, acc_next};
               ov_d    = 1'b1;
            end
         end
         ST_DONE: begin
            if (bus.out_ready) begin
               state_d = ST_IDLE;
               ov_d    = 1'b0;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         c_q     <= '0;
         acc_q   <= '0;
         info_q  <= '0;
         cw_q    <= '0;
         ov_q    <= 1'b0;
         g_q     <= '0;
      end else begin
         state_q <= state_d;
         c_q     <= c_d;
         acc_q   <= acc_d;
         info_q  <= info_d;
         cw_q    <= cw_d;
         ov_q    <= ov_d;
         g_q     <= g_d;
      end
   end
endmodule
